// File: rtl/branch_pkg.sv
// Shared types and constants for the branch unit controller and its history table.
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_RSV2 = 3'b010;
    localparam logic [2:0] F3_RSV3 = 3'b011;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAL  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    typedef logic [1:0] bht_ctr_t;
    localparam bht_ctr_t BHT_RESET = 2'b01;

    function automatic bht_ctr_t bht_next(input bht_ctr_t ctr, input logic taken);
        bht_ctr_t nxt;
        nxt = ctr;
        if (taken && ctr != 2'b11) begin
            nxt = ctr + 2'd1;
        end else if (!taken && ctr != 2'b00) begin
            nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

    // Reserved encodings resolve as not-taken.
    function automatic logic br_taken(input logic [2:0] funct3, input logic eq, input logic lt);
        logic t;
        case (funct3)
            F3_BEQ:           t = eq;
            F3_BNE:           t = !eq;
            F3_BLT, F3_BLTU:  t = lt;
            F3_BGE, F3_BGEU:  t = !lt;
            default:          t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/branch_unit_ctrl_if.sv
// Decode-to-branch-unit instruction handshake.
interface branch_unit_ctrl_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_imm;
    logic [2:0]  in_funct3;
    logic        in_is_branch;
    logic        in_is_jal;
    logic        in_is_jalr;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic        in_pred_taken;

    modport master (
        output in_valid, in_pc, in_imm, in_funct3,
        output in_is_branch, in_is_jal, in_is_jalr,
        output in_rs1, in_rs2, in_pred_taken,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_pc, in_imm, in_funct3,
        input  in_is_branch, in_is_jal, in_is_jalr,
        input  in_rs1, in_rs2, in_pred_taken,
        output in_ready
    );

endinterface

// File: rtl/branch_bht.sv
// Branch history table: 2-bit saturating counters, combinational lookup, registered update.
module branch_bht
    import branch_pkg::*;
#(
    parameter int BHT_ENTRIES = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [$clog2(BHT_ENTRIES)-1:0] lookup_idx,
    output logic                           lookup_taken,
    input  logic                           upd_en,
    input  logic [$clog2(BHT_ENTRIES)-1:0] upd_idx,
    input  logic                           upd_taken
);

    bht_ctr_t ctr [BHT_ENTRIES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                ctr[i] <= BHT_RESET;
            end
        end else if (upd_en) begin
            ctr[upd_idx] <= bht_next(ctr[upd_idx], upd_taken);
        end
    end

    // A same-cycle update is not visible here until the next cycle.
    assign lookup_taken = ctr[lookup_idx][1];

endmodule

// File: rtl/branch_unit_ctrl.sv
// Branch/jump resolution controller: sequences the external comparator, checks fetch's
// prediction, issues redirect/flush and keeps the branch history table.
//
//   state | meaning
//   IDLE  | ready for the next control-flow instruction from decode
//   EVAL  | comparator operands presented; resolve, redirect, link, train BHT
//   FLUSH | mispredict tail: hold flush until FLUSH_CYCLES total have elapsed
module branch_unit_ctrl
    import branch_pkg::*;
#(
    parameter int BHT_ENTRIES  = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    branch_unit_ctrl_if.slave  dec,
    output logic [31:0]        cmp_a,
    output logic [31:0]        cmp_b,
    output logic               cmp_un,
    input  logic               cmp_eq,
    input  logic               cmp_lt,
    output logic               redirect_valid,
    output logic [31:0]        redirect_pc,
    output logic               flush,
    output logic               link_valid,
    output logic [31:0]        link_data,
    output logic               illegal_br,
    input  logic [31:0]        bht_lookup_pc,
    output logic               bht_pred_taken,
    output logic [31:0]        stat_branches,
    output logic [31:0]        stat_mispredicts
);

    localparam int IDXW       = $clog2(BHT_ENTRIES);
    localparam int FCW        = $clog2(FLUSH_CYCLES + 1);
    localparam int FLUSH_LOAD = (FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0;

    state_t         state;
    logic [31:0]    pc_q;
    logic [31:0]    imm_q;
    logic [2:0]     funct3_q;
    logic           is_br_q;
    logic           is_jal_q;
    logic           is_jalr_q;
    logic           pred_q;
    logic [FCW-1:0] flush_cnt;

    logic           in_eval;
    logic           in_has_class;
    logic           f3_illegal;
    logic           taken;
    logic           mispredict;
    logic [31:0]    pc_plus4;
    logic [31:0]    target;
    logic [31:0]    next_pc;
    logic           unused_lookup_bits;

    assign in_eval      = (state == EVAL);
    assign in_has_class = dec.in_is_branch | dec.in_is_jal | dec.in_is_jalr;
    assign dec.in_ready = (state == IDLE);

    assign f3_illegal = (funct3_q == F3_RSV2) || (funct3_q == F3_RSV3);
    assign taken      = is_br_q ? br_taken(funct3_q, cmp_eq, cmp_lt) : (is_jal_q | is_jalr_q);
    assign pc_plus4   = pc_q + 32'd4;
    // cmp_a doubles as the latched rs1 for the JALR target.
    assign target     = is_jalr_q ? ((cmp_a + imm_q) & ~32'd1) : (pc_q + imm_q);
    assign next_pc    = taken ? target : pc_plus4;

    always_comb begin
        mispredict = 1'b0;
        if (is_br_q) begin
            mispredict = !f3_illegal && (taken != pred_q);
        end else if (is_jal_q) begin
            mispredict = !pred_q;
        end else if (is_jalr_q) begin
            mispredict = 1'b1;
        end
    end

    // Resolution depends on the comparator result in the EVAL cycle itself,
    // so the event outputs are decoded from the state rather than registered.
    assign redirect_valid = in_eval & mispredict;
    assign redirect_pc    = redirect_valid ? next_pc : '0;
    assign flush          = redirect_valid | (state == FLUSH);
    assign link_valid     = in_eval & (is_jal_q | is_jalr_q);
    assign link_data      = link_valid ? pc_plus4 : '0;
    assign illegal_br     = in_eval & is_br_q & f3_illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            pc_q             <= '0;
            imm_q            <= '0;
            funct3_q         <= '0;
            is_br_q          <= 1'b0;
            is_jal_q         <= 1'b0;
            is_jalr_q        <= 1'b0;
            pred_q           <= 1'b0;
            cmp_a            <= '0;
            cmp_b            <= '0;
            cmp_un           <= 1'b0;
            flush_cnt        <= '0;
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dec.in_valid && in_has_class) begin
                        pc_q      <= dec.in_pc;
                        imm_q     <= dec.in_imm;
                        funct3_q  <= dec.in_funct3;
                        is_br_q   <= dec.in_is_branch;
                        is_jal_q  <= dec.in_is_jal;
                        is_jalr_q <= dec.in_is_jalr;
                        pred_q    <= dec.in_pred_taken;
                        cmp_a     <= dec.in_rs1;
                        cmp_b     <= dec.in_rs2;
                        cmp_un    <= dec.in_funct3[1];
                        state     <= EVAL;
                    end
                end
                EVAL: begin
                    if (is_br_q) begin
                        stat_branches <= stat_branches + 32'd1;
                    end
                    if (mispredict) begin
                        stat_mispredicts <= stat_mispredicts + 32'd1;
                        if (FLUSH_CYCLES > 1) begin
                            flush_cnt <= FCW'(FLUSH_LOAD);
                            state     <= FLUSH;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        flush_cnt <= flush_cnt - FCW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    branch_bht #(
        .BHT_ENTRIES (BHT_ENTRIES)
    ) u_bht (
        .clk          (clk),
        .rst_n        (rst_n),
        .lookup_idx   (bht_lookup_pc[2 +: IDXW]),
        .lookup_taken (bht_pred_taken),
        .upd_en       (in_eval & is_br_q),
        .upd_idx      (pc_q[2 +: IDXW]),
        .upd_taken    (taken)
    );

    assign unused_lookup_bits = ^{bht_lookup_pc[31:2+IDXW], bht_lookup_pc[1:0]};

endmodule

// File: tb/tb_branch_unit_ctrl.sv
// Scoreboard bench for branch_unit_ctrl: a driver pushes expected resolutions computed
// from the branch rules; a monitor pops and compares them against the DUT each cycle.
module tb_branch_unit_ctrl;

    localparam int BHT_ENTRIES  = 16;
    localparam int FLUSH_CYCLES = 2;

    typedef struct {
        int unsigned due;
        bit          rv;
        logic [31:0] rpc;
        bit          lv;
        logic [31:0] ld;
        bit          ill;
        bit          cun;
        bit          is_br;
        bit          taken;
        int          idx;
        bit          misp;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] cmp_a, cmp_b;
    logic        cmp_un, cmp_eq, cmp_lt;
    logic        redirect_valid, flush, link_valid, illegal_br, bht_pred_taken;
    logic [31:0] redirect_pc, link_data, stat_branches, stat_mispredicts;
    logic [31:0] bht_lookup_pc;

    branch_unit_ctrl_if dif ();

    branch_unit_ctrl #(
        .BHT_ENTRIES  (BHT_ENTRIES),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .dec              (dif),
        .cmp_a            (cmp_a),
        .cmp_b            (cmp_b),
        .cmp_un           (cmp_un),
        .cmp_eq           (cmp_eq),
        .cmp_lt           (cmp_lt),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .flush            (flush),
        .link_valid       (link_valid),
        .link_data        (link_data),
        .illegal_br       (illegal_br),
        .bht_lookup_pc    (bht_lookup_pc),
        .bht_pred_taken   (bht_pred_taken),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    // External combinational comparator.
    always_comb begin
        cmp_eq = (cmp_a == cmp_b);
        cmp_lt = cmp_un ? (cmp_a < cmp_b) : ($signed(cmp_a) < $signed(cmp_b));
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          checks = 0;
    int          errors = 0;
    exp_t        q[$];
    int          m_bht[BHT_ENTRIES];
    int unsigned m_branches = 0;
    int unsigned m_misp = 0;
    int          flush_left = 0;
    bit          mon_en = 0;
    logic [31:0] last_rpc = '0;
    logic [31:0] last_ld = '0;
    bit          lk_fixed = 0;
    logic [31:0] lk_pc = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int bht_idx(input logic [31:0] pc);
        return int'((pc >> 2) % BHT_ENTRIES);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < BHT_ENTRIES; i++) m_bht[i] = 1;
        m_branches = 0;
        m_misp     = 0;
        flush_left = 0;
        q.delete();
    endtask

    initial begin
        bht_lookup_pc = '0;
        forever begin
            @(posedge clk);
            #1;
            bht_lookup_pc = lk_fixed ? lk_pc : $urandom;
        end
    end

    // Monitor: compares the DUT against the expectation queue once per cycle.
    exp_t e;
    bit   is_eval;
    int   lidx;
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            is_eval = (q.size() > 0) && (q[0].due == cyc);
            lidx    = bht_idx(bht_lookup_pc);
            chk("bht_pred", bht_pred_taken, (m_bht[lidx] >= 2) ? 1 : 0);
            chk("stat_branches", stat_branches, m_branches);
            chk("stat_mispredicts", stat_mispredicts, m_misp);
            chk("in_ready", dif.in_ready, (!is_eval && flush_left == 0) ? 1 : 0);
            if (is_eval) begin
                e = q.pop_front();
                chk("redirect_valid", redirect_valid, e.rv);
                if (e.rv) chk("redirect_pc", redirect_pc, e.rpc);
                chk("link_valid", link_valid, e.lv);
                if (e.lv) chk("link_data", link_data, e.ld);
                chk("illegal_br", illegal_br, e.ill);
                chk("cmp_un", cmp_un, e.cun);
                if (e.misp) flush_left = FLUSH_CYCLES;
                if (e.rv) last_rpc = redirect_pc;
                if (e.lv) last_ld = link_data;
            end else begin
                chk("idle_pulses", {redirect_valid, link_valid, illegal_br}, 3'b000);
            end
            chk("flush", flush, (flush_left > 0) ? 1 : 0);
            if (flush_left > 0) flush_left--;
            if (is_eval) begin
                if (e.is_br) begin
                    m_branches++;
                    if (e.taken) m_bht[e.idx] = (m_bht[e.idx] < 3) ? m_bht[e.idx] + 1 : 3;
                    else         m_bht[e.idx] = (m_bht[e.idx] > 0) ? m_bht[e.idx] - 1 : 0;
                end
                if (e.misp) m_misp++;
            end
            if (q.size() > 0 && q[0].due < cyc) begin
                chk("missed_eval", q[0].due, cyc);
                void'(q.pop_front());
            end
        end
    end

    // Driver: offers one instruction, holds it until accepted, records the expected result.
    task automatic send(input logic [2:0] cls, input logic [2:0] f3, input logic [31:0] pc,
                        input logic [31:0] imm, input logic [31:0] rs1, input logic [31:0] rs2,
                        input bit pred);
        int   w = 0;
        exp_t x;
        bit   taken, ill;
        logic [31:0] tgt;
        @(negedge clk);
        dif.in_valid      = 1'b1;
        dif.in_is_branch  = cls[0];
        dif.in_is_jal     = cls[1];
        dif.in_is_jalr    = cls[2];
        dif.in_funct3     = f3;
        dif.in_pc         = pc;
        dif.in_imm        = imm;
        dif.in_rs1        = rs1;
        dif.in_rs2        = rs2;
        dif.in_pred_taken = pred;
        while (!dif.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) begin
            chk("accept_timeout", 32'(w), 32'd0);
        end else if (cls != 3'b000) begin
            case (f3)
                3'd0:    taken = (rs1 == rs2);
                3'd1:    taken = (rs1 != rs2);
                3'd4:    taken = ($signed(rs1) < $signed(rs2));
                3'd5:    taken = !($signed(rs1) < $signed(rs2));
                3'd6:    taken = (rs1 < rs2);
                3'd7:    taken = !(rs1 < rs2);
                default: taken = 1'b0;
            endcase
            if (!cls[0]) taken = 1'b1;
            ill     = cls[0] && (f3 == 3'd2 || f3 == 3'd3);
            tgt     = cls[2] ? ((rs1 + imm) & 32'hFFFF_FFFE) : (pc + imm);
            x.due   = cyc + 1;
            x.misp  = cls[0] ? (!ill && taken != pred) : (cls[1] ? !pred : 1'b1);
            x.rv    = x.misp;
            x.rpc   = taken ? tgt : pc + 32'd4;
            x.lv    = !cls[0];
            x.ld    = pc + 32'd4;
            x.ill   = ill;
            x.cun   = f3[1];
            x.is_br = cls[0];
            x.taken = taken;
            x.idx   = bht_idx(pc);
            q.push_back(x);
        end
        @(posedge clk);
        #1;
        dif.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int w = 0;
        @(negedge clk);
        while (!dif.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) chk("idle_timeout", 32'(w), 32'd0);
    endtask

    task automatic check_all_bht_zero(input string name);
        lk_fixed = 1;
        for (int i = 0; i < BHT_ENTRIES; i++) begin
            lk_pc = 32'(i) << 2;
            @(posedge clk);
            #2;
            chk(name, bht_pred_taken, 1'b0);
        end
        lk_fixed = 0;
    endtask

    localparam logic [2:0] C_BR = 3'b001, C_JAL = 3'b010, C_JALR = 3'b100;

    logic [2:0]  r_cls;
    logic [31:0] r_rs1, r_rs2, base_br;
    int          sel;

    initial begin
        dif.in_valid = 0; dif.in_is_branch = 0; dif.in_is_jal = 0; dif.in_is_jalr = 0;
        dif.in_funct3 = 0; dif.in_pc = 0; dif.in_imm = 0; dif.in_rs1 = 0; dif.in_rs2 = 0;
        dif.in_pred_taken = 0;
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_in_ready", dif.in_ready, 1'b1);
        chk("rst_flush", flush, 1'b0);
        chk("rst_stats", stat_branches | stat_mispredicts, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check_all_bht_zero("rst_bht");

        mon_en = 1;

        // Same index (0) trained taken three times, then not-taken.
        lk_fixed = 1;
        lk_pc    = 32'h100;
        @(posedge clk); #2;
        chk("bht_seq0", bht_pred_taken, 1'b0);
        send(C_BR, 3'd0, 32'h100, 32'h20, 32'd7, 32'd7, 1'b1);
        wait_idle();
        chk("bht_seq1", bht_pred_taken, 1'b1);
        send(C_BR, 3'd0, 32'h100, 32'h20, 32'd7, 32'd7, 1'b1);
        wait_idle();
        chk("bht_seq2", bht_pred_taken, 1'b1);
        send(C_BR, 3'd0, 32'h100, 32'h20, 32'd7, 32'd7, 1'b1);
        wait_idle();
        send(C_BR, 3'd0, 32'h100, 32'h20, 32'd7, 32'd8, 1'b0);
        wait_idle();
        chk("bht_sat_nt1", bht_pred_taken, 1'b1);
        send(C_BR, 3'd0, 32'h100, 32'h20, 32'd7, 32'd8, 1'b0);
        wait_idle();
        chk("bht_sat_nt2", bht_pred_taken, 1'b0);
        lk_fixed = 0;

        // BEQ taken but predicted not-taken.
        send(C_BR, 3'd0, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0);
        wait_idle();
        chk("beq_redirect_pc", last_rpc, 32'h120);
        chk("beq_mispredicts", stat_mispredicts, 32'd1);

        // BLTU vs BLT with 0xFFFFFFFF / 1.
        send(C_BR, 3'd6, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b0);
        wait_idle();
        chk("bltu_no_misp", stat_mispredicts, 32'd1);
        send(C_BR, 3'd4, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b0);
        wait_idle();
        chk("blt_redirect_pc", last_rpc, 32'h240);

        // JALR target clears bit 0.
        send(C_JALR, 3'd0, 32'h40, 32'h10, 32'h203, 32'd0, 1'b0);
        wait_idle();
        chk("jalr_redirect_pc", last_rpc, 32'h212);
        chk("jalr_link_data", last_ld, 32'h44);

        // Reserved funct3 counts as a branch, never as a mispredict.
        base_br = stat_branches;
        send(C_BR, 3'd2, 32'h300, 32'h8, 32'd1, 32'd1, 1'b1);
        wait_idle();
        chk("illegal_branches", stat_branches, base_br + 32'd1);

        // Dropped instruction with no class bit set.
        send(3'b000, 3'd0, 32'h500, 32'h4, 32'd0, 32'd0, 1'b1);

        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 9);
            r_cls = (sel == 0) ? 3'b000 : (sel <= 5) ? C_BR : (sel <= 7) ? C_JAL : C_JALR;
            r_rs1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
            r_rs2 = ($urandom_range(0, 3) == 0) ? r_rs1 : $urandom;
            send(r_cls, 3'($urandom_range(0, 7)), {$urandom_range(0, 255), 2'b00} + 32'h1000,
                 $urandom, r_rs1, r_rs2, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle();
        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 32'd0);

        // Reset asserted while in FLUSH.
        mon_en = 0;
        send(C_BR, 3'd0, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0);
        @(posedge clk);
        #2;
        chk("pre_rst_flush", flush, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ready", dif.in_ready, 1'b1);
        chk("rst_mid_outs", {flush, redirect_valid, link_valid, illegal_br, cmp_un}, 5'b0);
        chk("rst_mid_stat_b", stat_branches, 32'd0);
        chk("rst_mid_stat_m", stat_mispredicts, 32'd0);
        chk("rst_mid_cmp", cmp_a | cmp_b, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        check_all_bht_zero("rst_mid_bht");
        chk("post_rst_ready", dif.in_ready, 1'b1);

        mon_en = 1;
        send(C_JAL, 3'd0, 32'h80, 32'h100, 32'd0, 32'd0, 1'b0);
        wait_idle();
        chk("post_rst_jal_rpc", last_rpc, 32'h180);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
